// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, MEM-resolved branch squashes
// and multi-cycle mult/div occupancy of EX.
module hazard_ctrl #(
  parameter int MD_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_md_start,
  input  logic        mem_branch_taken,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_bubble,
  output logic        md_unit_start,
  output logic        md_done,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    RUN,
    BUSY
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] cnt;
  logic [5:0] cnt_nxt;
  logic       lu_hit;

  assign lu_hit = ex_mem_read && (ex_rt != 5'd0) &&
                  ((id_use_rs && (id_rs == ex_rt)) ||
                   (id_use_rt && (id_rt == ex_rt)));

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    md_unit_start = 1'b0;
    md_done       = 1'b0;
    md_busy       = 1'b0;
    state_nxt     = state;
    cnt_nxt       = cnt;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mem_branch_taken) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
          end else if (ex_md_start) begin
            md_unit_start = 1'b1;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            state_nxt     = BUSY;
            cnt_nxt       = 6'(MD_LATENCY - 1);
          end else if (lu_hit) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        BUSY: begin
          md_busy = 1'b1;
          if (cnt > 6'd1) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            cnt_nxt       = cnt - 6'd1;
          end else begin
            // last EX cycle: op moves on, ID may still need a load-use stall
            md_done   = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = 6'd0;
            if (lu_hit) begin
              pc_en        = 1'b0;
              if_id_en     = 1'b0;
              id_ex_bubble = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= 6'd0;
      stall_cycles <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_en) stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
